// File: rtl/mem_ctrl_multi.sv
// mem_ctrl_multi: arbitrates NUM_CH requesters onto an 8-bit memory bus,
// serialising byte/half/word accesses little-endian with pipelined read capture.
module mem_ctrl_multi #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int RR_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [2*NUM_CH-1:0]      size,
  input  logic [ADDR_W*NUM_CH-1:0] addr,
  input  logic [32*NUM_CH-1:0]     wdata,
  output logic [NUM_CH-1:0]        ack,
  output logic [31:0]              rdata,
  output logic                     busy,
  output logic [2:0]               grant_id,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t              state;
  logic [2:0]          cnt, ptr, win, n;
  logic [1:0]          lat_size, sel_size;
  logic [31:0]         lat_wdata, sel_wdata;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_we, wr_q;
  logic [2*NUM_CH-1:0] rot;
  int                  s;
  assign n = lat_size == 2'd0 ? 3'd1 : lat_size == 2'd1 ? 3'd2 : 3'd4;
  assign mem_wr = wr_q & rdy;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ack
    assign ack[i] = rdy && state == DONE && grant_id == 3'(i);
  end
  // Rotate requests so the scan starts at the round-robin pointer.
  always_comb begin
    rot = {req, req} >> ((RR_MODE != 0) ? ptr : 3'd0);
    win = '0;
    s = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      s = k + ((RR_MODE != 0) ? int'(ptr) : 0);
      if (rot[k]) win = 3'(s >= NUM_CH ? s - NUM_CH : s);
    end
    sel_we = 1'b0;
    sel_size = '0;
    sel_addr = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (win == 3'(k)) begin
        sel_we = we[k];
        sel_size = size[2*k +: 2];
        sel_addr = addr[k*ADDR_W +: ADDR_W];
        sel_wdata = wdata[32*k +: 32];
      end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      grant_id <= '0;
      lat_size <= '0;
      lat_wdata <= '0;
      rdata <= '0;
      busy <= 1'b0;
      mem_a <= '0;
      mem_dout <= '0;
      wr_q <= 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: if (|req) begin
          grant_id <= win;
          lat_size <= sel_size;
          lat_wdata <= sel_wdata;
          mem_a <= sel_addr;
          cnt <= '0;
          busy <= 1'b1;
          wr_q <= sel_we;
          state <= sel_we ? WR : RD;
          if (sel_we) mem_dout <= sel_wdata[7:0];
          else rdata <= '0;
        end
        RD: begin
          if (cnt != 3'd0) rdata[{cnt - 3'd1, 3'b000} +: 8] <= mem_din;
          if (cnt + 3'd1 < n) mem_a <= mem_a + ADDR_W'(1);
          cnt <= cnt + 3'd1;
          if (cnt == n) state <= DONE;
        end
        WR: if (cnt + 3'd1 < n) begin
          mem_a <= mem_a + ADDR_W'(1);
          mem_dout <= lat_wdata[{cnt + 3'd1, 3'b000} +: 8];
          cnt <= cnt + 3'd1;
        end else begin
          wr_q <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
          if (RR_MODE != 0) ptr <= grant_id == 3'(NUM_CH - 1) ? 3'd0 : grant_id + 3'd1;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_ctrl_multi.sv
// tb_mem_ctrl_multi: transaction-level model check of a fixed-priority 2-channel
// controller plus directed checks of a 3-channel round-robin instance.
module tb_mem_ctrl_multi;
  logic        clk, rst, rdy;
  logic [1:0]  req0, we0, ack0;
  logic [3:0]  size0;
  logic [63:0] addr0, wdata0;
  logic [31:0] rdata0, a0;
  logic        busy0, wr0;
  logic [2:0]  gid0;
  logic [7:0]  din0, dout0;
  logic [2:0]  req1, ack1, gid1;
  logic [5:0]  size1;
  logic [95:0] addr1;
  logic [31:0] rdata1, a1;
  logic        busy1, wr1;
  logic [7:0]  din1, dout1;
  int cmp_n = 0, err_n = 0;
  logic [7:0] wmem [0:65535];
  bit         wflag [0:65535];

  mem_ctrl_multi #(.NUM_CH(2), .ADDR_W(32), .RR_MODE(0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req(req0), .we(we0), .size(size0),
    .addr(addr0), .wdata(wdata0), .ack(ack0), .rdata(rdata0), .busy(busy0),
    .grant_id(gid0), .mem_din(din0), .mem_dout(dout0), .mem_a(a0), .mem_wr(wr0));

  mem_ctrl_multi #(.NUM_CH(3), .ADDR_W(32), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .rdy(rdy), .req(req1), .we(3'b000), .size(size1),
    .addr(addr1), .wdata(96'd0), .ack(ack1), .rdata(rdata1), .busy(busy1),
    .grant_id(gid1), .mem_din(din1), .mem_dout(dout1), .mem_a(a1), .mem_wr(wr1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(logic [15:0] a);
    case (a)
      16'h0100: return 8'h11;
      16'h0101: return 8'h22;
      16'h0102: return 8'h33;
      16'h0103: return 8'h44;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] memrd(logic [15:0] a);
    return wflag[a] ? wmem[a] : pat(a);
  endfunction

  // External memory: one-cycle read latency, frozen together with the controller.
  always @(posedge clk) if (rdy) begin
    din0 <= memrd(a0[15:0]);
    din1 <= memrd(a1[15:0]);
  end
  always @(posedge clk) if (wr0) begin
    wmem[a0[15:0]] <= dout0;
    wflag[a0[15:0]] <= 1'b1;
  end

  function automatic int nb(logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] rdval(logic [31:0] b, int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = memrd(16'(b + 32'(i)));
    return v;
  endfunction

  // Model: t counts active cycles since grant; done at t = n (write) or n+1 (read).
  logic        m_act, m_started, m_we;
  int          m_t, m_n, m_done, m_gid, m_win;
  logic [31:0] m_base, m_wd, m_rd_exp, m_rdata;
  assign m_win = req0[0] ? 0 : 1;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_act <= 1'b0;
      m_started <= 1'b0;
      m_we <= 1'b0;
      m_t <= 0;
      m_n <= 1;
      m_done <= 0;
      m_gid <= 0;
      m_base <= '0;
      m_wd <= '0;
      m_rd_exp <= '0;
      m_rdata <= '0;
    end else if (rdy) begin
      if (m_act) begin
        if (m_t == m_done) begin
          m_act <= 1'b0;
          if (!m_we) m_rdata <= m_rd_exp;
        end else m_t <= m_t + 1;
      end else if (req0 != 2'b00) begin
        m_act <= 1'b1;
        m_started <= 1'b1;
        m_t <= 0;
        m_gid <= m_win;
        m_base <= addr0[32*m_win +: 32];
        m_n <= nb(size0[2*m_win +: 2]);
        m_we <= we0[m_win];
        m_wd <= wdata0[32*m_win +: 32];
        m_done <= nb(size0[2*m_win +: 2]) + (we0[m_win] ? 0 : 1);
        m_rd_exp <= rdval(addr0[32*m_win +: 32], nb(size0[2*m_win +: 2]));
      end
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [1:0]  ea;
    logic [31:0] exa;
    logic        ew;
    @(negedge clk);
    ea = (m_act && m_t == m_done && rdy) ? (2'b01 << m_gid) : 2'b00;
    exa = m_started ? m_base + 32'((m_t < m_n - 1) ? m_t : m_n - 1) : 32'd0;
    ew = m_act && m_we && m_t < m_n && rdy;
    chk("busy", 32'(busy0), 32'(m_act));
    chk("grant_id", 32'(gid0), 32'(m_gid));
    chk("ack", 32'(ack0), 32'(ea));
    chk("mem_a", a0, exa);
    chk("mem_wr", 32'(wr0), 32'(ew));
    if (ew) chk("mem_dout", 32'(dout0), 32'(m_wd[8*m_t +: 8]));
    if (!m_started) chk("mem_dout_rst", 32'(dout0), 32'd0);
    if (!(m_act && !m_we)) chk("rdata_hold", rdata0, m_rdata);
    else if (m_t == m_done) chk("rdata_rd", rdata0, m_rd_exp);
    #2;
  endtask

  logic [31:0] lg_a [0:15];
  logic [31:0] lg_rd [0:15];
  logic [7:0]  lg_do [0:15];
  logic [1:0]  lg_ack [0:15];
  logic [2:0]  lg_gid [0:15];
  logic        lg_wr [0:15];

  task automatic cyc(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      step();
      lg_a[i] = a0;
      lg_rd[i] = rdata0;
      lg_do[i] = dout0;
      lg_ack[i] = ack0;
      lg_gid[i] = gid0;
      lg_wr[i] = wr0;
      req0 = req0 & ~ack0;
    end
  endtask

  task automatic set_req(input logic ch, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    we0[ch] = w;
    size0[2*ch +: 2] = sz;
    addr0[32*ch +: 32] = a;
    wdata0[32*ch +: 32] = d;
    req0[ch] = 1'b1;
  endtask

  initial begin
    int exp_ch, nacks;
    rst = 1'b0;
    rdy = 1'b1;
    req0 = '0;
    we0 = '0;
    size0 = '0;
    addr0 = '0;
    wdata0 = '0;
    req1 = '0;
    size1 = '0;
    addr1 = {32'h302, 32'h301, 32'h300};
    repeat (3) step();
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_mem_a", a0, 32'd0);
    chk("rst_rdata", rdata0, 32'd0);
    rst = 1'b1;
    step();

    set_req(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    cyc(1, 7);
    for (int i = 1; i <= 4; i++) chk("rd_addr_step", lg_a[i], 32'h100 + 32'(i - 1));
    chk("rd_ack_early", 32'(lg_ack[5]), 32'd0);
    chk("rd_ack_lat6", 32'(lg_ack[6]), 32'd1);
    chk("rd_word", lg_rd[6], 32'h44332211);

    set_req(1'b1, 1'b1, 2'd1, 32'h2000, 32'h1234BEEF);
    cyc(1, 1);
    wdata0[63:32] = 32'h0;
    cyc(2, 4);
    chk("wr_b0_en", 32'(lg_wr[1]), 32'd1);
    chk("wr_b0_a", lg_a[1], 32'h2000);
    chk("wr_b0_d", 32'(lg_do[1]), 32'hEF);
    chk("wr_b1_en", 32'(lg_wr[2]), 32'd1);
    chk("wr_b1_a", lg_a[2], 32'h2001);
    chk("wr_b1_d", 32'(lg_do[2]), 32'hBE);
    chk("wr_end", 32'(lg_wr[3]), 32'd0);
    chk("wr_ack", 32'(lg_ack[3]), 32'd2);
    chk("wr_rdata_hold", lg_rd[3], 32'h44332211);
    chk("mem_2000", 32'(memrd(16'h2000)), 32'hEF);
    chk("mem_2001", 32'(memrd(16'h2001)), 32'hBE);
    chk("mem_2002", 32'(memrd(16'h2002)), 32'h58);

    set_req(1'b0, 1'b0, 2'd0, 32'h101, 32'h0);
    set_req(1'b1, 1'b0, 2'd1, 32'h102, 32'h0);
    cyc(1, 10);
    chk("both_gid_first", 32'(lg_gid[1]), 32'd0);
    chk("both_ack0", 32'(lg_ack[3]), 32'd1);
    chk("both_rd0", lg_rd[3], 32'h22);
    chk("both_gid_second", 32'(lg_gid[5]), 32'd1);
    chk("both_ack1", 32'(lg_ack[8]), 32'd2);
    chk("both_rd1", lg_rd[8], 32'h4433);

    set_req(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    cyc(1, 2);
    rdy = 1'b0;
    cyc(3, 5);
    rdy = 1'b1;
    cyc(6, 10);
    for (int i = 3; i <= 5; i++) begin
      chk("frz_addr", lg_a[i], 32'h101);
      chk("frz_wr", 32'(lg_wr[i]), 32'd0);
      chk("frz_ack", 32'(lg_ack[i]), 32'd0);
    end
    chk("frz_ack_nominal", 32'(lg_ack[6]), 32'd0);
    chk("frz_ack_delayed", 32'(lg_ack[9]), 32'd1);
    chk("frz_rdata", lg_rd[9], 32'h44332211);

    set_req(1'b1, 1'b1, 2'd2, 32'h400, 32'hCAFEF00D);
    cyc(1, 3);
    chk("pre_rst_wr", 32'(wr0), 32'd1);
    chk("pre_rst_a", a0, 32'h402);
    rst = 1'b0;
    #1;
    chk("arst_mem_a", a0, 32'd0);
    chk("arst_mem_wr", 32'(wr0), 32'd0);
    chk("arst_dout", 32'(dout0), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_ack", 32'(ack0), 32'd0);
    chk("arst_gid", 32'(gid0), 32'd0);
    chk("arst_rdata", rdata0, 32'd0);
    req0 = '0;
    cyc(4, 5);
    rst = 1'b1;
    chk("mem_400", 32'(memrd(16'h400)), 32'h0D);
    chk("mem_401", 32'(memrd(16'h401)), 32'hF0);
    chk("mem_402_untouched", 32'(memrd(16'h402)), 32'h58);
    set_req(1'b0, 1'b0, 2'd1, 32'h102, 32'h0);
    cyc(1, 5);
    chk("post_rst_a0", lg_a[1], 32'h102);
    chk("post_rst_a1", lg_a[2], 32'h103);
    chk("post_rst_ack", 32'(lg_ack[4]), 32'd1);
    chk("post_rst_rd", lg_rd[4], 32'h4433);

    req1 = 3'b111;
    exp_ch = 0;
    nacks = 0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (ack1 != 3'b000) begin
        chk("rr_ack", 32'(ack1), 32'(3'b001 << exp_ch));
        chk("rr_gid", 32'(gid1), 32'(exp_ch));
        chk("rr_rdata", rdata1, 32'(memrd(16'h300 + 16'(exp_ch))));
        exp_ch = (exp_ch + 1) % 3;
        nacks++;
      end
    end
    chk("rr_count", 32'(nacks), 32'd6);
    req1 = '0;
    repeat (5) step();
    chk("rr_idle", 32'(busy1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
